io_region_ctrl: RTL

//  Parametrised memory-mapped IO controller between the uniciclo core's data port and the

---
 rtl/io_region_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/io_region_ctrl.sv
// Memory-mapped IO controller: registered region decode with one-hot enables and offsets,
// a fixed two-stage read return path, and sticky clear-on-read push-button registers.
module io_region_ctrl #(
   parameter int unsigned ADDR_W = 22,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned N_REG  = 5,
   parameter logic [N_REG*ADDR_W-1:0] REG_BASE =
      {22'd307320, 22'd120, 22'd116, 22'd100, 22'd0},
   parameter logic [N_REG*ADDR_W-1:0] REG_LIMIT =
      {22'd614512, 22'd307319, 22'd116, 22'd100, 22'd96},
   parameter int unsigned BTN_N    = 3,
   parameter int unsigned BTN_BASE = 104,
   localparam int unsigned SEL_W   = (BTN_N > 1) ? $clog2(BTN_N) : 1,
   localparam int unsigned IDX_W   = (N_REG > 1) ? $clog2(N_REG) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   input  logic                    req_we,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [DATA_W-1:0]       req_wdata,
   input  logic [N_REG*DATA_W-1:0] reg_rdata,
   input  logic [BTN_N-1:0]        btn_raw,
   output logic [N_REG-1:0]        reg_en,
   output logic                    reg_we,
   output logic [ADDR_W-1:0]       reg_off,
   output logic [DATA_W-1:0]       reg_wdata,
   output logic                    rd_valid,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    err,
   output logic [SEL_W-1:0]        btn_sel
);

   // Stage 0 decode
   logic              region_hit;
   logic [IDX_W-1:0]  hit_idx;
   logic [ADDR_W-1:0] hit_off;
   logic [BTN_N-1:0]  btn_hit;
   logic              btn_hit_any;
   logic [SEL_W-1:0]  btn_idx;
   logic              region_en;
   logic [N_REG-1:0]  reg_en_d;

   // Stage 1 / stage 2 state
   logic [N_REG-1:0]  reg_en_q;
   logic              reg_we_q;
   logic [ADDR_W-1:0] reg_off_q;
   logic [DATA_W-1:0] reg_wdata_q;
   logic              err_q;
   logic              s1_rd_q;
   logic              s1_btn_q;
   logic              s1_btn_val_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rdata_sel;

   // Button state
   logic [BTN_N-1:0]  sync1_q;
   logic [BTN_N-1:0]  sync2_q;
   logic [BTN_N-1:0]  prev_q;
   logic [BTN_N-1:0]  sticky_q;
   logic [BTN_N-1:0]  sticky_d;
   logic [BTN_N-1:0]  btn_edge;
   logic [BTN_N-1:0]  btn_clr;
   logic [SEL_W-1:0]  btn_sel_q;
   logic [SEL_W-1:0]  btn_sel_d;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      region_hit = 1'b0;
      hit_idx    = '0;
      for (int i = N_REG - 1; i >= 0; i--) begin
         if (req_addr >= REG_BASE[i*ADDR_W +: ADDR_W] &&
             req_addr <= REG_LIMIT[i*ADDR_W +: ADDR_W]) begin
            region_hit = 1'b1;
            hit_idx    = IDX_W'(i);
         end
      end
      hit_off = req_addr - REG_BASE[hit_idx*ADDR_W +: ADDR_W];
   end

   always_comb begin
      btn_hit     = '0;
      btn_hit_any = 1'b0;
      btn_idx     = '0;
      for (int i = BTN_N - 1; i >= 0; i--) begin
         if (req_addr == ADDR_W'(BTN_BASE + 4 * i)) begin
            btn_hit[i]  = 1'b1;
            btn_hit_any = 1'b1;
            btn_idx     = SEL_W'(i);
         end
      end
   end

   assign region_en = region_hit && !btn_hit_any;
   assign reg_en_d  = region_en ? (N_REG'(1) << hit_idx) : '0;

   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < N_REG; i++) begin
         if (reg_en_q[i]) rdata_sel = rdata_sel | reg_rdata[i*DATA_W +: DATA_W];
      end
   end

   // A new edge overrides a same-cycle clear, so a press is never lost.
   assign btn_edge = sync2_q & ~prev_q;
   assign btn_clr  = (req_valid && (!req_we || req_wdata[0])) ? btn_hit : '0;
   assign sticky_d = (sticky_q & ~btn_clr) | btn_edge;

   always_comb begin
      btn_sel_d = btn_sel_q;
      for (int i = BTN_N - 1; i >= 0; i--) begin
         if (btn_edge[i]) btn_sel_d = SEL_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg_en_q     <= '0;
         reg_we_q     <= 1'b0;
         reg_off_q    <= '0;
         reg_wdata_q  <= '0;
         err_q        <= 1'b0;
         s1_rd_q      <= 1'b0;
         s1_btn_q     <= 1'b0;
         s1_btn_val_q <= 1'b0;
      end else begin
         reg_en_q     <= req_valid ? reg_en_d : '0;
         reg_we_q     <= req_valid && region_en && req_we;
         err_q        <= req_valid && !region_hit && !btn_hit_any;
         s1_rd_q      <= req_valid && !req_we;
         s1_btn_q     <= btn_hit_any;
         s1_btn_val_q <= sticky_q[btn_idx];
         if (req_valid && region_en) begin
            reg_off_q   <= hit_off;
            reg_wdata_q <= req_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= s1_rd_q;
         if (s1_rd_q) begin
            if (s1_btn_q)   rd_data_q <= DATA_W'(s1_btn_val_q);
            else if (err_q) rd_data_q <= '0;
            else            rd_data_q <= rdata_sel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         sticky_q  <= '0;
         btn_sel_q <= '0;
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         sticky_q  <= sticky_d;
         btn_sel_q <= btn_sel_d;
      end
   end

   assign reg_en    = reg_en_q;
   assign reg_we    = reg_we_q;
   assign reg_off   = reg_off_q;
   assign reg_wdata = reg_wdata_q;
   assign err       = err_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign btn_sel   = btn_sel_q;

endmodule
